// File: rtl/pc_sequencer.sv
// Program counter register and next-PC selector with stall buffering, one-deep
// redirect capture, misalignment trap and halt.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        jump_en,
  input  logic [31:0] jump_target,
  input  logic        branch_en,
  input  logic [31:0] branch_offset,
  input  logic        jr_en,
  input  logic [31:0] jr_addr,
  input  logic        halt,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [3:0]  pc4_upper,
  output logic        fetch_valid,
  output logic        misaligned,
  output logic        halted
);

  typedef enum logic [1:0] {BOOT, RUN, HOLD, HALTED} state_t;

  state_t      state, state_n;
  logic [31:0] pc_n;
  logic [31:0] pend_addr, pend_addr_n;
  logic        pend_vld, pend_vld_n;
  logic        mis_n;
  logic        req_vld;
  logic [31:0] req_addr;
  logic        hold_has;
  logic [31:0] hold_tgt;

  assign pc_plus4    = pc + 32'd4;
  assign pc4_upper   = pc_plus4[31:28];
  assign fetch_valid = (state == RUN);
  assign halted      = (state == HALTED);

  assign req_vld = jr_en | jump_en | branch_en;

  always_comb begin
    req_addr = pc_plus4 + branch_offset;
    if (jr_en)
      req_addr = jr_addr;
    else if (jump_en)
      req_addr = jump_target;
  end

  // A request in the cycle stall drops is newer than anything already pending.
  always_comb begin
    hold_has = req_vld | pend_vld;
    hold_tgt = req_vld ? req_addr : pend_addr;
  end

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    pend_vld_n  = pend_vld;
    pend_addr_n = pend_addr;
    mis_n       = misaligned;
    case (state)
      BOOT: state_n = halt ? HALTED : RUN;
      RUN: begin
        if (halt) begin
          state_n = HALTED;
        end else if (stall) begin
          state_n = HOLD;
          if (req_vld) begin
            pend_vld_n  = 1'b1;
            pend_addr_n = req_addr;
          end
        end else if (req_vld) begin
          if (req_addr[1:0] != 2'b00) begin
            state_n = HALTED;
            mis_n   = 1'b1;
          end else begin
            pc_n = req_addr;
          end
        end else begin
          pc_n = pc_plus4;
        end
      end
      HOLD: begin
        if (halt) begin
          state_n    = HALTED;
          pend_vld_n = 1'b0;
        end else if (stall) begin
          if (req_vld) begin
            pend_vld_n  = 1'b1;
            pend_addr_n = req_addr;
          end
        end else begin
          state_n    = RUN;
          pend_vld_n = 1'b0;
          if (!hold_has) begin
            pc_n = pc_plus4;
          end else if (hold_tgt[1:0] != 2'b00) begin
            state_n = HALTED;
            mis_n   = 1'b1;
          end else begin
            pc_n = hold_tgt;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      pend_vld   <= 1'b0;
      pend_addr  <= 32'd0;
      misaligned <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      pend_vld   <= pend_vld_n;
      pend_addr  <= pend_addr_n;
      misaligned <= mis_n;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: driver steps a behavioural model and queues
// expectations; a negedge monitor pops and compares against the DUT.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, jump_en = 1'b0, branch_en = 1'b0, jr_en = 1'b0, halt = 1'b0;
  logic [31:0] jump_target = '0, branch_offset = '0, jr_addr = '0;
  logic [31:0] pc, pc_plus4;
  logic [3:0]  pc4_upper;
  logic        fetch_valid, misaligned, halted;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic        fv;
    logic        mis;
    logic        hlt;
  } exp_t;

  exp_t exp_q[$];

  // Behavioural model state
  logic [31:0] m_pc;
  bit          m_boot, m_hold, m_halted, m_mis;
  logic [31:0] m_pend[$];

  pc_sequencer #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .jump_en(jump_en), .jump_target(jump_target),
    .branch_en(branch_en), .branch_offset(branch_offset),
    .jr_en(jr_en), .jr_addr(jr_addr), .halt(halt),
    .pc(pc), .pc_plus4(pc_plus4), .pc4_upper(pc4_upper),
    .fetch_valid(fetch_valid), .misaligned(misaligned), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t cur_exp();
    exp_t e;
    e.pc  = m_pc;
    e.fv  = !m_boot && !m_hold && !m_halted;
    e.mis = m_mis;
    e.hlt = m_halted;
    return e;
  endfunction

  task automatic model_reset();
    m_pc = RST_PC; m_boot = 1; m_hold = 0; m_halted = 0; m_mis = 0;
    m_pend.delete();
  endtask

  // Apply one rising edge worth of behaviour using the inputs currently driven.
  task automatic model_step();
    logic [31:0] tgt, t;
    bit has;
    has = jr_en || jump_en || branch_en;
    tgt = jr_en ? jr_addr : jump_en ? jump_target : m_pc + 32'd4 + branch_offset;
    if (m_halted) begin
    end else if (m_boot) begin
      m_boot = 0;
      if (halt) m_halted = 1;
    end else if (!m_hold) begin
      if (halt) m_halted = 1;
      else if (stall) begin
        m_hold = 1;
        if (has) begin m_pend.delete(); m_pend.push_back(tgt); end
      end else if (has) begin
        if (tgt % 4 != 0) begin m_mis = 1; m_halted = 1; end
        else m_pc = tgt;
      end else m_pc = m_pc + 32'd4;
    end else begin
      if (halt) begin
        m_halted = 1; m_hold = 0; m_pend.delete();
      end else begin
        if (has) begin m_pend.delete(); m_pend.push_back(tgt); end
        if (!stall) begin
          m_hold = 0;
          if (m_pend.size() > 0) begin
            t = m_pend.pop_front();
            if (t % 4 != 0) begin m_mis = 1; m_halted = 1; end
            else m_pc = t;
          end else m_pc = m_pc + 32'd4;
          m_pend.delete();
        end
      end
    end
  endtask

  task automatic clr();
    stall = 0; jump_en = 0; branch_en = 0; jr_en = 0; halt = 0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
    if (rst_n) model_step();
    exp_q.push_back(cur_exp());
  endtask

  // Asynchronous reset asserted mid-cycle; the monitor sees it before the next edge.
  task automatic do_reset();
    #2;
    rst_n = 0;
    model_reset();
    exp_q[exp_q.size()-1] = cur_exp();
    clr();
    cyc();
    cyc();
    rst_n = 1;
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc", pc, e.pc);
        chk("pc_plus4", pc_plus4, e.pc + 32'd4);
        chk("pc4_upper", {28'd0, pc4_upper}, {28'd0, 4'((e.pc + 32'd4) >> 28)});
        chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, e.fv});
        chk("misaligned", {31'd0, misaligned}, {31'd0, e.mis});
        chk("halted", {31'd0, halted}, {31'd0, e.hlt});
      end
    end
  end

  // Driver
  initial begin
    int halted_cycles;
    logic [31:0] r;
    model_reset();
    clr();
    cyc();
    cyc();
    rst_n = 1;

    // Run sequentially up to 0x00400010, then jump and branch together
    for (int i = 0; i < 20 && m_pc != 32'h0040_0010; i++) begin clr(); cyc(); end
    jump_en = 1; jump_target = 32'h0040_0100; branch_en = 1; branch_offset = 32'h0000_0040;
    cyc();
    clr(); jr_en = 1; jr_addr = 32'h0040_0020; cyc();
    clr(); branch_en = 1; branch_offset = 32'hFFFF_FFF0; cyc();
    clr(); jr_en = 1; jr_addr = 32'h0040_0003; cyc();
    clr(); cyc(); cyc();
    do_reset();

    // Stall window with two redirects; the later jr wins
    clr(); cyc(); cyc();
    stall = 1; jump_en = 1; jump_target = 32'h0040_0200; cyc();
    clr(); stall = 1; jr_en = 1; jr_addr = 32'h0040_0300; cyc();
    clr(); stall = 1; cyc();
    clr(); cyc();
    cyc();

    // Wrap-around
    jr_en = 1; jr_addr = 32'hFFFF_FFFC; cyc();
    clr(); cyc(); cyc();

    // Reset while holding a pending redirect
    stall = 1; jump_en = 1; jump_target = 32'h0040_0400; cyc();
    clr(); stall = 1; cyc();
    do_reset();
    clr(); cyc(); cyc(); cyc();

    // Randomised phase
    halted_cycles = 0;
    for (int n = 0; n < 600; n++) begin
      clr();
      stall     = ($urandom_range(0, 4) == 0);
      jr_en     = ($urandom_range(0, 7) == 0);
      jump_en   = ($urandom_range(0, 7) == 0);
      branch_en = ($urandom_range(0, 7) == 0);
      halt      = ($urandom_range(0, 79) == 0);
      r = $urandom;
      jr_addr = {r[31:2], 2'b00};
      if ($urandom_range(0, 29) == 0) jr_addr[1:0] = 2'($urandom_range(1, 3));
      r = m_pc + 32'd4;
      jump_target = {r[31:28], 26'($urandom), 2'b00};
      branch_offset = 32'(($urandom_range(0, 2047) - 1024) * 4);
      cyc();
      halted_cycles = m_halted ? halted_cycles + 1 : 0;
      if (halted_cycles >= 3 || $urandom_range(0, 149) == 0) begin
        do_reset();
        halted_cycles = 0;
      end
    end
    clr();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
